// File: rtl/post_processing_pkg.sv
// Shared definitions for the Montgomery post-processing block: defaults and FSM encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package post_processing_pkg;

  localparam int PP_WIDTH = 256;
  localparam int PP_CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HALVE   = 2'b01,
    ST_CORRECT = 2'b10,
    ST_DONE    = 2'b11
  } pp_state_t;

endpackage

// File: rtl/post_processing_mod_halve.sv
// Radix-2 modular halving: (acc + (acc odd ? n : 0)) / 2, summed at WIDTH+1 bits.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module post_processing_mod_halve
  import post_processing_pkg::*;
#(
  parameter int WIDTH = PP_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH:0] sum;
  logic           unused_lsb;

  // Adding n to an odd acc makes the sum even (n odd), so the shift is exact.
  assign sum        = {1'b0, acc} + (acc[0] ? {1'b0, n} : {(WIDTH+1){1'b0}});
  assign res        = sum[WIDTH:1];
  assign unused_lsb = sum[0];

endmodule

// File: rtl/post_processing.sv
// Removes the Montgomery factor: out = A * 2^-K mod N via K halvings plus a final subtract loop.
// Latency: K+2 cycles from the accepting edge to out_ready when A<N (more when A>=N).
// Backpressure: none; in_valid is ignored whenever busy or in DONE. Optional: POST_PROCESSING_MODCHECK_EN adds err.
module post_processing
  import post_processing_pkg::*;
#(
  parameter int WIDTH = PP_WIDTH,
  parameter int CNT_W = PP_CNT_W
) (
  input  logic             clk,
  input  logic             beg,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] N,
  input  logic [CNT_W-1:0] K,
  output logic [WIDTH-1:0] out,
  output logic             out_ready,
  output logic             busy,
  output logic [1:0]       state
`ifdef POST_PROCESSING_MODCHECK_EN
  ,
  output logic             err
`endif
);

  pp_state_t        cur_st, nxt_st;
  logic [WIDTH-1:0] acc, nreg, halved;
  logic [CNT_W-1:0] kreg, cnt, k_clamped;
  logic             acc_ge_n, last_step, bad_n;

  post_processing_mod_halve #(.WIDTH(WIDTH)) u_halve (
    .acc (acc),
    .n   (nreg),
    .res (halved)
  );

  assign k_clamped = (K > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : K;
  assign acc_ge_n  = (acc >= nreg);
  assign last_step = ((cnt + CNT_W'(1)) == kreg);
`ifdef POST_PROCESSING_MODCHECK_EN
  assign bad_n     = ~N[0];
`else
  assign bad_n     = (N == '0);
`endif
  assign busy      = (cur_st != ST_IDLE);
  assign state     = cur_st;

  // State register.
  always_ff @(posedge clk or negedge beg) begin
    if (!beg) cur_st <= ST_IDLE;
    else      cur_st <= nxt_st;
  end

  // Next-state logic: halve K times, subtract until below N, then publish.
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE: begin
        if (in_valid) begin
          if (bad_n)          nxt_st = ST_DONE;
          else if (K == '0)   nxt_st = ST_CORRECT;
          else                nxt_st = ST_HALVE;
        end
      end
      ST_HALVE:   if (last_step) nxt_st = ST_CORRECT;
      ST_CORRECT: if (!acc_ge_n) nxt_st = ST_DONE;
      ST_DONE:    nxt_st = ST_IDLE;
      default:    nxt_st = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, halving steps, correction and result register.
  always_ff @(posedge clk or negedge beg) begin
    if (!beg) begin
      acc       <= '0;
      nreg      <= '0;
      kreg      <= '0;
      cnt       <= '0;
      out       <= '0;
      out_ready <= 1'b0;
`ifdef POST_PROCESSING_MODCHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      out_ready <= (cur_st == ST_DONE);
      case (cur_st)
        ST_IDLE: begin
          if (in_valid) begin
            nreg <= N;
            kreg <= k_clamped;
            cnt  <= '0;
`ifdef POST_PROCESSING_MODCHECK_EN
            err  <= bad_n;
            acc  <= bad_n ? '0 : A;
`else
            acc  <= A;
`endif
          end
        end
        ST_HALVE: begin
          acc <= halved;
          cnt <= cnt + CNT_W'(1);
        end
        ST_CORRECT: if (acc_ge_n) acc <= acc - nreg;
        ST_DONE:    out <= acc;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_post_processing.sv
module tb_post_processing;

  typedef struct {
    logic [255:0] val;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         beg;
  logic         in_valid;
  logic [255:0] A, N;
  logic [8:0]   K;
  logic [255:0] out;
  logic         out_ready, busy;
  logic [1:0]   state;
`ifdef POST_PROCESSING_MODCHECK_EN
  logic         err;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;

  post_processing dut (
    .clk       (clk),
    .beg       (beg),
    .in_valid  (in_valid),
    .A         (A),
    .N         (N),
    .K         (K),
    .out       (out),
    .out_ready (out_ready),
    .busy      (busy),
    .state     (state)
`ifdef POST_PROCESSING_MODCHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference via multiplication by (N+1)/2, the inverse of 2 mod odd N.
  function automatic logic [255:0] golden(input logic [255:0] a, input logic [255:0] n, input int k);
    logic [511:0] r, inv, n_w;
    int kk;
    kk  = (k > 256) ? 256 : k;
    n_w = {256'd0, n};
    inv = {256'd0, (n >> 1) + 256'd1};
    r   = {256'd0, a} % n_w;
    for (int i = 0; i < kk; i++) r = (r * inv) % n_w;
    return r[255:0];
  endfunction

  // Pulses in_valid for one cycle; returns at the negedge right after the accepting edge (lat=0).
  task automatic start_op(input logic [255:0] a, input logic [255:0] n, input int k,
                          input bit push, input logic [255:0] exp_val, input int exp_lat);
    exp_t e;
    @(negedge clk);
    A = a; N = n; K = k[8:0]; in_valid = 1'b1;
    if (push) begin
      e.val = exp_val;
      e.lat = exp_lat;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    while (!out_ready && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ready"}, {255'd0, out_ready}, 256'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 256'd0, 256'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 256'(lat), 256'(e.lat));
      chk({tag, "_out"}, out, e.val);
    end
    chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
  endtask

  initial begin
    logic [255:0] nbig, ra, rn;
    int rk, seen;

    beg = 1'b0; in_valid = 1'b0; A = '0; N = '0; K = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", {254'd0, state}, 256'd0);
    chk("rst_out", out, 256'd0);
    chk("rst_ready", {255'd0, out_ready}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    beg = 1'b1;

    // A=5 N=13 K=4: accumulator walk 5 -> 9 -> 11 -> 12 -> 6
    start_op(256'd5, 256'd13, 4, 1'b1, 256'd6, 6);
    chk("t1_state", {254'd0, state}, 256'd1);
    chk("t1_acc0", dut.acc, 256'd5);
    @(negedge clk); lat++; chk("t1_acc1", dut.acc, 256'd9);
    @(negedge clk); lat++; chk("t1_acc2", dut.acc, 256'd11);
    @(negedge clk); lat++; chk("t1_acc3", dut.acc, 256'd12);
    @(negedge clk); lat++; chk("t1_acc4", dut.acc, 256'd6);
    chk("t1_corr", {254'd0, state}, 256'd2);
    wait_result("t1");

    // K=0, A<N: single CORRECT cycle
    start_op(256'd7, 256'd13, 0, 1'b1, 256'd7, 2);
    wait_result("t2");

    // K=0, A>=N: seven subtract cycles
    start_op(256'd100, 256'd13, 0, 1'b1, 256'd9, 9);
    wait_result("t3");

    // Full width, K=256, A=N-1
    nbig = '1;
    nbig = nbig - 256'd188;
    start_op(nbig - 256'd1, nbig, 256, 1'b1, golden(nbig - 256'd1, nbig, 256), 258);
    wait_result("t4");

    // K above WIDTH clamps to WIDTH
    start_op(256'd1234, 256'd100003, 300, 1'b1, golden(256'd1234, 256'd100003, 300), 258);
    wait_result("t5");

    // in_valid during HALVE must be ignored
    start_op(256'd5, 256'd13, 4, 1'b1, 256'd6, 6);
    A = 256'd1; in_valid = 1'b1;
    @(negedge clk); lat++;
    in_valid = 1'b0;
    wait_result("t6");
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_ready) seen++;
    end
    chk("t6_no_extra", 256'(seen), 256'd0);

    // Reset on the second HALVE cycle aborts the operation
    start_op(256'd5, 256'd13, 4, 1'b0, 256'd0, 0);
    @(negedge clk);
    chk("t7_halve", {254'd0, state}, 256'd1);
    beg = 1'b0;
    #1;
    chk("t7_state", {254'd0, state}, 256'd0);
    chk("t7_out", out, 256'd0);
    chk("t7_acc", dut.acc, 256'd0);
    chk("t7_busy", {255'd0, busy}, 256'd0);
    @(negedge clk);
    beg = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_ready) seen++;
    end
    chk("t7_no_ready", 256'(seen), 256'd0);

`ifdef POST_PROCESSING_MODCHECK_EN
    // Even modulus is rejected immediately
    start_op(256'd5, 256'd12, 4, 1'b1, 256'd0, 1);
    wait_result("t8");
    chk("t8_err", {255'd0, err}, 256'd1);
    start_op(256'd5, 256'd13, 4, 1'b1, 256'd6, 6);
    wait_result("t9");
    chk("t9_err", {255'd0, err}, 256'd0);
`else
    // N=0 passes A through via DONE
    start_op(256'h55, 256'd0, 4, 1'b1, 256'h55, 1);
    wait_result("t8");
`endif

    // Random small operands with A<N
    for (int i = 0; i < 6; i++) begin
      rn = 256'($urandom) | 256'd1;
      ra = 256'($urandom) % rn;
      rk = $urandom_range(0, 40);
      start_op(ra, rn, rk, 1'b1, golden(ra, rn, rk), rk + 2);
      wait_result($sformatf("rnd%0d", i));
    end

    chk("sb_empty", 256'(sb.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/post_processing.md
Name: post_processing

Overview:
- Inverse of the RSA pre-processing step: removes the 2^K Montgomery factor, computing out = A * 2^-K mod N.
- Uses K radix-2 halving steps, then a final modular correction.
- Sits after the Montgomery multiplier and consumes a one-cycle valid pulse in the same style the pre-processor produces.
- Multi-cycle, one operand set in flight at a time.

Parameters:
- WIDTH, 256, operand width of A, N and out.
- CNT_W, 9, width of K and of the internal step counter; holds 0..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- beg  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle pulse; A, N, K sampled on the clk edge where it is high
- A  in  WIDTH  value to reduce (any value < 2^WIDTH)
- N  in  WIDTH  modulus; odd for a defined result
- K  in  CNT_W  number of halvings, 0..WIDTH
- out  out  WIDTH  result; held until the next accepted operation
- out_ready  out  1  registered one-cycle pulse when out is valid
- busy  out  1  high in every state except IDLE
- state  out  2  FSM state, for observation

Behaviour:
- Reset (beg=0, async): state=IDLE, acc=0, out=0, out_ready=0, busy=0, counter=0.
- States: IDLE=00, HALVE=01, CORRECT=10, DONE=11.
- IDLE:
  - On in_valid, latch A into acc, N into nreg, K into kreg, counter=0.
  - If N==0: go to DONE with acc=A unchanged.
  - Else if K==0: go to CORRECT.
  - Else: go to HALVE.
- HALVE, one step per cycle:
  - acc odd: acc=(acc+nreg)>>1, with the sum formed at WIDTH+1 bits so there is no overflow.
  - acc even: acc=acc>>1.
  - counter++; after the step that makes counter==kreg, go to CORRECT.
  - Invariant: acc < 2^WIDTH always, since (acc+N)/2 < 2^WIDTH.
- CORRECT: if acc>=nreg, acc-=nreg and stay; else go to DONE.
  - Loops for inputs with A>=N; exactly one cycle when A<N.
- DONE: out<=acc, out_ready=1 for this single cycle, then IDLE.
- Latency, A<N, N!=0: out_ready is high K+2 cycles after the accepting edge (HALVE K cycles, CORRECT 1, DONE 1).
- in_valid while busy is ignored: no latch, no queueing.
- in_valid in the DONE cycle is ignored; it is accepted again from IDLE onward.
- Even N: FSM terminates with the same cycle count; the value is unspecified.
- K>WIDTH: clamped to WIDTH at latch time.
- Reset mid-operation: immediate return to reset values. out_ready never fires for the aborted operation.
- out changes only in DONE or on reset.

Optional Feature:
- Macro: POST_PROCESSING_MODCHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0).
  - In IDLE, if the latched N is even or zero: skip HALVE/CORRECT, go straight to DONE with out=0, err=1, out_ready pulsed.
  - err clears on the next accepted in_valid.
- When undefined: no err port; N==0 passes A through; even N gives an unspecified result.

Decomposition:
- Shared package:
  - state encodings IDLE/HALVE/CORRECT/DONE
  - WIDTH and CNT_W defaults
- Sub-module mod_halve: combinational, acc,N -> (acc + (acc[0]?N:0))>>1 at WIDTH+1 bits. Natural for reuse by the Montgomery multiplier's reduction step.
- Compare/subtract for CORRECT stays inline.

Test Plan:
- A=5, N=13, K=4 -> acc sequence 9,11,12,6; out=6; out_ready at cycle 6 after acceptance; busy low after.
- A=7, N=13, K=0 -> out=7, out_ready 2 cycles after acceptance.
- A=100, N=13, K=0 -> CORRECT loops 7 cycles; out=9; out_ready 9 cycles after acceptance.
- N=2^256-189, A=N-1, K=256 -> out matches golden A*2^-256 mod N; no overflow; out_ready at cycle 258.
- A=5, N=13, K=4: second in_valid in HALVE with A=1 -> ignored, out=6. Pull beg low on the 2nd HALVE cycle -> out=0, state=IDLE, no out_ready.
- With POST_PROCESSING_MODCHECK_EN: N=12 -> out=0, err=1, out_ready 1 cycle after acceptance. Then A=5, N=13, K=4 -> err=0, out=6.
